// File: rtl/arbitro_sumador_if.sv
// Request/operand bus of the round-robin saturating adder.
// The DUT takes the slave modport and the requesters the master modport.
interface arbitro_sumador_if #(
  parameter int Width = 4
);
  // Handshake: requester i holds req[i] with its operands stable. A
  // one-cycle gnt[i] means A/B were captured and req[i] must drop. done
  // pulses for one cycle when Y/Y_id/ovf carry the result.
  logic [3:0]         req;
  logic [4*Width-1:0] A_in;
  logic [4*Width-1:0] B_in;
  logic [3:0]         gnt;
  logic               busy;
  logic               done;
  logic [Width-1:0]   Y;
  logic [1:0]         Y_id;
  logic               ovf;
  logic [7:0]         ovf_count;

  modport master (
    output req, A_in, B_in,
    input  gnt, busy, done, Y, Y_id, ovf, ovf_count
  );

  modport slave (
    input  req, A_in, B_in,
    output gnt, busy, done, Y, Y_id, ovf, ovf_count
  );
endinterface

// File: rtl/arbitro_sumador.sv
// Four-requester round-robin arbiter feeding one saturating two's-complement
// adder. Each served request takes IDLE -> CALC -> DONE, and all outputs are registered.
module arbitro_sumador #(
  parameter int Width     = 4,
  parameter int Signo     = 1,
  parameter int Magnitud  = 2,
  parameter int Presicion = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  arbitro_sumador_if.slave     bus,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  if (Signo + Magnitud + Presicion != Width) begin : g_fmt_check
    $error("arbitro_sumador: Signo+Magnitud+Presicion must equal Width");
  end

  localparam logic [Width-1:0] PosSat = {1'b0, {(Width-1){1'b1}}};
  localparam logic [Width-1:0] NegSat = {1'b1, {(Width-2){1'b0}}, 1'b1};

  state_t           state;
  logic [1:0]       last;
  logic [1:0]       win_q;
  logic [Width-1:0] a_q;
  logic [Width-1:0] b_q;

  logic [1:0]       winner;
  logic             found;
  logic [Width-1:0] sum;
  logic             pos_ovf;
  logic             neg_ovf;

  assign state_dbg = state;

  // Search upward from the requester after the last one served.
  always_comb begin
    winner = last;
    found  = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (!found && bus.req[last + 2'(k)]) begin
        winner = last + 2'(k);
        found  = 1'b1;
      end
    end
  end

  // The fixed-point split does not matter here: the sum is plain two's complement.
  always_comb begin
    sum     = a_q + b_q;
    pos_ovf = !a_q[Width-1] && !b_q[Width-1] &&  sum[Width-1];
    neg_ovf =  a_q[Width-1] &&  b_q[Width-1] && !sum[Width-1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      last          <= 2'd3;
      win_q         <= 2'd0;
      a_q           <= '0;
      b_q           <= '0;
      bus.gnt       <= 4'b0000;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.Y         <= '0;
      bus.Y_id      <= 2'd0;
      bus.ovf       <= 1'b0;
      bus.ovf_count <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (found) begin
            a_q      <= bus.A_in[winner*Width +: Width];
            b_q      <= bus.B_in[winner*Width +: Width];
            win_q    <= winner;
            last     <= winner;
            bus.gnt  <= 4'b0001 << winner;
            bus.busy <= 1'b1;
            state    <= CALC;
          end
        end
        CALC: begin
          bus.gnt  <= 4'b0000;
          bus.done <= 1'b1;
          bus.Y_id <= win_q;
          bus.ovf  <= pos_ovf || neg_ovf;
          if (pos_ovf)      bus.Y <= PosSat;
          else if (neg_ovf) bus.Y <= NegSat;
          else              bus.Y <= sum;
          if ((pos_ovf || neg_ovf) && bus.ovf_count != 8'hFF)
            bus.ovf_count <= bus.ovf_count + 8'd1;
          state    <= DONE;
        end
        DONE: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          bus.gnt  <= 4'b0000;
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arbitro_sumador.sv
// Directed bench for arbitro_sumador: grant order, saturation, the ovf counter
// and asynchronous reset. Inputs change and outputs are sampled on the falling edge.
module tb_arbitro_sumador;

  logic       clk;
  logic       reset;
  logic [1:0] state_dbg;
  int         n_total;
  int         n_pass;
  int         exp_cnt;

  arbitro_sumador_if #(.Width(4)) bus ();

  arbitro_sumador #(
    .Width(4), .Signo(1), .Magnitud(2), .Presicion(1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h, required %0h", tag, obs, exp);
  endtask

  task automatic set_ops(input int i, input logic [3:0] a, input logic [3:0] b);
    bus.A_in[i*4 +: 4] = a;
    bus.B_in[i*4 +: 4] = b;
  endtask

  // Called on a falling edge with the DUT idle. It returns on the falling edge
  // of the following IDLE cycle, with req low.
  task automatic serve(input logic [3:0] r, input int id, input logic [3:0] ey, input logic eovf);
    bus.req = r;
    @(negedge clk);
    chk("calc_state", 32'(state_dbg), 32'd1);
    chk("gnt", 32'(bus.gnt), 32'(4'b0001 << id));
    chk("calc_busy", 32'(bus.busy), 32'd1);
    chk("calc_done", 32'(bus.done), 32'd0);
    bus.req = 4'b0000;
    @(negedge clk);
    if (eovf && exp_cnt < 255) exp_cnt++;
    chk("done_state", 32'(state_dbg), 32'd2);
    chk("done", 32'(bus.done), 32'd1);
    chk("done_gnt", 32'(bus.gnt), 32'd0);
    chk("Y", 32'(bus.Y), 32'(ey));
    chk("Y_id", 32'(bus.Y_id), 32'(id));
    chk("ovf", 32'(bus.ovf), 32'(eovf));
    chk("ovf_count", 32'(bus.ovf_count), 32'(exp_cnt));
    @(negedge clk);
    chk("idle_state", 32'(state_dbg), 32'd0);
    chk("idle_done", 32'(bus.done), 32'd0);
    chk("idle_busy", 32'(bus.busy), 32'd0);
    chk("Y_hold", 32'(bus.Y), 32'(ey));
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    exp_cnt = 0;
    reset   = 1'b1;
    bus.req  = 4'b0000;
    bus.A_in = '0;
    bus.B_in = '0;

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    chk("rst_state", 32'(state_dbg), 32'd0);
    chk("rst_gnt", 32'(bus.gnt), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_Y", 32'(bus.Y), 32'd0);
    chk("rst_Y_id", 32'(bus.Y_id), 32'd0);
    chk("rst_ovf", 32'(bus.ovf), 32'd0);
    chk("rst_cnt", 32'(bus.ovf_count), 32'd0);
    reset = 1'b0;

    // The FSM stays idle while req is 0.
    @(negedge clk);
    @(negedge clk);
    chk("idle_noreq_state", 32'(state_dbg), 32'd0);
    chk("idle_noreq_gnt", 32'(bus.gnt), 32'd0);

    // Plain sum 3 + 2 = 5.
    set_ops(1, 4'b0011, 4'b0010);
    serve(4'b0010, 1, 4'b0101, 1'b0);
    // Positive saturation 7 + 1 -> 7.
    set_ops(0, 4'b0111, 4'b0001);
    serve(4'b0001, 0, 4'b0111, 1'b1);
    // Negative saturation -8 + -1 -> 1001, then -2 + 3 = 1.
    set_ops(2, 4'b1000, 4'b1111);
    serve(4'b0100, 2, 4'b1001, 1'b1);
    set_ops(2, 4'b1110, 4'b0011);
    serve(4'b0100, 2, 4'b0001, 1'b0);
    // Both negative without overflow: -1 + -2 = -3.
    set_ops(1, 4'b1111, 4'b1110);
    serve(4'b0010, 1, 4'b1101, 1'b0);
    // Positive operands summing exactly to the maximum: 4 + 3 = 7.
    set_ops(3, 4'b0100, 4'b0011);
    serve(4'b1000, 3, 4'b0111, 1'b0);

    // req and operands changing during CALC/DONE must not disturb the result.
    set_ops(2, 4'b1000, 4'b1000);
    bus.req = 4'b0100;
    @(negedge clk);
    chk("noise_gnt", 32'(bus.gnt), 32'b0100);
    bus.req = 4'b1011;
    set_ops(2, 4'b0001, 4'b0001);
    @(negedge clk);
    if (exp_cnt < 255) exp_cnt++;
    chk("noise_done", 32'(bus.done), 32'd1);
    chk("noise_Y", 32'(bus.Y), 32'b1001);
    chk("noise_Y_id", 32'(bus.Y_id), 32'd2);
    chk("noise_ovf", 32'(bus.ovf), 32'd1);
    chk("noise_cnt", 32'(bus.ovf_count), 32'(exp_cnt));
    @(negedge clk);
    chk("noise_idle", 32'(state_dbg), 32'd0);
    bus.req = 4'b0000;
    @(negedge clk);
    chk("noise_no_regrant", 32'(bus.gnt), 32'd0);

    // Reset in CALC aborts the operation asynchronously.
    set_ops(0, 4'b0111, 4'b0001);
    set_ops(1, 4'b0011, 4'b0010);
    set_ops(2, 4'b1110, 4'b0011);
    set_ops(3, 4'b0001, 4'b0001);
    bus.req = 4'b0001;
    @(negedge clk);
    chk("abort_calc", 32'(state_dbg), 32'd1);
    bus.req = 4'b0000;
    #2 reset = 1'b1;
    #1;
    exp_cnt = 0;
    chk("abort_state", 32'(state_dbg), 32'd0);
    chk("abort_gnt", 32'(bus.gnt), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_Y", 32'(bus.Y), 32'd0);
    chk("abort_Y_id", 32'(bus.Y_id), 32'd0);
    chk("abort_ovf", 32'(bus.ovf), 32'd0);
    chk("abort_cnt", 32'(bus.ovf_count), 32'd0);
    @(negedge clk);
    chk("abort_no_done1", 32'(bus.done), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_no_done2", 32'(bus.done), 32'd0);

    // After reset requester 0 wins first, then requester 3.
    serve(4'b1001, 0, 4'b0111, 1'b1);
    serve(4'b1001, 3, 4'b0010, 1'b0);

    // Everybody requesting: rotation 0,1,2,3,0.
    serve(4'b1111, 0, 4'b0111, 1'b1);
    serve(4'b1111, 1, 4'b0101, 1'b0);
    serve(4'b1111, 2, 4'b0001, 1'b0);
    serve(4'b1111, 3, 4'b0010, 1'b0);
    serve(4'b1111, 0, 4'b0111, 1'b1);

    // Overflow counter saturates at 255.
    for (int n = 0; n < 300; n++) begin
      serve(4'b0001, 0, 4'b0111, 1'b1);
    end
    chk("cnt_sticky", 32'(bus.ovf_count), 32'd255);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/arbitro_sumador.md
ARBITRO_SUMADOR -- requirements
Module: arbitro_sumador

Interface
REQ-001 Parameter Width, default 4, total word width of each operand and of the result.
REQ-002 Parameter Signo, default 1, sign bits of the fixed-point format.
REQ-003 Parameter Magnitud, default 2, integer magnitude bits of the format.
REQ-004 Parameter Presicion, default 1, fractional bits; Signo+Magnitud+Presicion SHALL equal Width.
REQ-005 clk  in  1  single clock; all state changes on the rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 req  in  4  request bit per requester i (0..3).
REQ-008 A_in  in  4*Width  operand A of requester i at bits [i*Width +: Width], two's complement.
REQ-009 B_in  in  4*Width  operand B of requester i, same packing as A_in.
REQ-010 gnt  out  4  one-hot grant; operands of the granted requester have been captured.
REQ-011 busy  out  1  high whenever the FSM is not in IDLE.
REQ-012 done  out  1  one-cycle pulse; Y, Y_id and ovf are valid.
REQ-013 Y  out  Width  saturated sum of the served request.
REQ-014 Y_id  out  2  index of the requester that Y belongs to.
REQ-015 ovf  out  1  high when Y was saturated.
REQ-016 ovf_count  out  8  number of saturated results since reset, sticky at 255.

Function
REQ-017 The block SHALL implement FSM states IDLE, CALC and DONE, and every output SHALL be registered.
REQ-018 In IDLE with req==0 the FSM SHALL stay in IDLE with gnt=0 and done=0.
REQ-019 In IDLE with req!=0 the winner SHALL be the first set req bit searching upward from (last+1) mod 4.
REQ-020 On that edge the block SHALL latch the winner's A and B, set last=winner and gnt=onehot(winner), and go to CALC.
REQ-021 gnt SHALL be high for exactly the single CALC cycle and SHALL be cleared on the CALC->DONE edge.
REQ-022 On the CALC->DONE edge the block SHALL register Y=sat(A+B), ovf, Y_id=winner and done=1.
REQ-023 On the DONE->IDLE edge done SHALL clear, making done exactly a one-cycle pulse.
REQ-024 Timing: req sampled at edge k gives gnt in cycle k+1, done/Y in cycle k+2, and the next sample at the end of cycle k+3.
REQ-025 A requester SHALL drop req within one cycle of seeing gnt; req still high in IDLE SHALL be treated as a new request.
REQ-026 Addition SHALL be Width-bit two's complement; the fixed-point format is transparent to the sum.
REQ-027 Positive overflow (both operands non-negative, sum MSB=1) SHALL give Y=2^(Width-1)-1 with ovf=1.
REQ-028 Negative overflow (both operands negative, sum MSB=0) SHALL give Y=-(2^(Width-1)-1), i.e. 1000..01, with ovf=1.
REQ-029 Otherwise Y SHALL be the raw sum with ovf=0.
REQ-030 Y, Y_id and ovf SHALL hold their values until the next done.
REQ-031 ovf_count SHALL increment on each result with ovf=1 and SHALL hold at 255 (no wrap).
REQ-032 req changes during CALC or DONE SHALL not affect the operation in progress.

Reset
REQ-033 Asserting reset SHALL immediately force IDLE with gnt, done, busy, Y, Y_id, ovf and ovf_count all 0, and last=3.
REQ-034 Reset during CALC or DONE SHALL abort the operation with no done pulse.
REQ-035 After reset is released, requester 0 SHALL have the highest priority.

Verification
REQ-036 With Width=4, req=0010, A1=0011, B1=0010 -> gnt=0010 for one cycle, then done=1, Y=0101, Y_id=1, ovf=0.
REQ-037 With req=1111 re-raised after every grant -> grant order 0,1,2,3,0, with one done per grant.
REQ-038 A0=0111, B0=0001 -> Y=0111, ovf=1, ovf_count=1.
REQ-039 A2=1000, B2=1111 -> Y=1001, ovf=1; A2=1110, B2=0011 -> Y=0001, ovf=0.
REQ-040 Reset asserted in CALC -> all outputs 0 asynchronously, no done; a later req=1001 is granted to requester 0 first.
REQ-041 300 consecutive overflowing operations -> ovf_count reaches 255 and stays at 255.
